// File: rtl/hwpe_periph_initiator.sv
// Single-outstanding initiator for the HWPE periph bus: one register read/write per command, response returned with data or timeout error.
// Optional statistics counters are built when HWPE_PERIPH_INITIATOR_STATS_EN is defined; otherwise stat_wr_o/stat_rd_o read 0.
module hwpe_periph_initiator #(
    parameter int ID             = 10,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [31:0]   cmd_addr_i,
    input  logic [31:0]   cmd_wdata_i,
    input  logic [3:0]    cmd_be_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          periph_req_o,
    output logic [31:0]   periph_add_o,
    output logic          periph_wen_o,
    output logic [3:0]    periph_be_o,
    output logic [31:0]   periph_data_o,
    output logic [ID-1:0] periph_id_o,
    input  logic          periph_gnt_i,
    input  logic [31:0]   periph_r_data_i,
    input  logic          periph_r_valid_i,
    input  logic [ID-1:0] periph_r_id_i,
    output logic [15:0]   mismatch_cnt_o,
    output logic [31:0]   stat_wr_o,
    output logic [31:0]   stat_rd_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

    state_t          state_q, state_d;
    logic            wen_q, wen_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [ID-1:0]   id_q, id_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [15:0]     mm_q, mm_d;
    logic            busy, timeout, rsp_hs;

    // Timeout fires in the cycle whose increment brings the count to TIMEOUT_CYCLES,
    // so a transaction gets exactly TIMEOUT_CYCLES cycles in REQ+WAIT_R.
    assign busy    = (state_q == REQ) || (state_q == WAIT_R);
    assign timeout = busy && ((cnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES));
    assign rsp_hs  = (state_q == RESP) && rsp_ready_i;

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mm_d    = mm_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    wen_d   = ~cmd_we_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    be_d    = cmd_be_i;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                cnt_d = cnt_q + TO_W'(1);
                if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (periph_gnt_i) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + TO_W'(1);
                if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (periph_r_valid_i && (periph_r_id_i == id_q)) begin
                    rdata_d = wen_q ? periph_r_data_i : 32'h0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    id_d    = id_q + ID'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Responses seen while the request is still pending are not ours to judge.
        if (periph_r_valid_i && (state_q != REQ) && (periph_r_id_i != id_q) && (mm_q != 16'hFFFF)) begin
            mm_d = mm_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mm_q    <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mm_q    <= mm_d;
        end
    end

    assign cmd_ready_o    = (state_q == IDLE) && !rst_i;
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_rdata_o    = rdata_q;
    assign rsp_err_o      = err_q;
    assign periph_req_o   = (state_q == REQ) && !timeout;
    assign periph_add_o   = addr_q;
    assign periph_wen_o   = wen_q;
    assign periph_be_o    = be_q;
    assign periph_data_o  = wdata_q;
    assign periph_id_o    = id_q;
    assign mismatch_cnt_o = mm_q;

`ifdef HWPE_PERIPH_INITIATOR_STATS_EN
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_rd_q, stat_rd_d;

    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (rsp_hs && !err_q) begin
            if (!wen_q) stat_wr_d = stat_wr_q + 32'd1;
            else        stat_rd_d = stat_rd_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_wr_o = stat_wr_q;
    assign stat_rd_o = stat_rd_q;
`else
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
    assign stat_wr_o     = 32'h0;
    assign stat_rd_o     = 32'h0;
`endif

endmodule

// File: tb/tb_hwpe_periph_initiator.sv
// Bench for hwpe_periph_initiator with ID=2, TIMEOUT_CYCLES=8: vector table, random transactions, timeout and reset sequences.
module tb_hwpe_periph_initiator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic [3:0]  cmd_be_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        periph_req_o, periph_wen_o, periph_gnt_i, periph_r_valid_i;
    logic [31:0] periph_add_o, periph_data_o, periph_r_data_i;
    logic [3:0]  periph_be_o;
    logic [1:0]  periph_id_o, periph_r_id_i;
    logic [15:0] mismatch_cnt_o;
    logic [31:0] stat_wr_o, stat_rd_o;

    hwpe_periph_initiator #(.ID(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .periph_req_o(periph_req_o), .periph_add_o(periph_add_o),
        .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
        .periph_id_o(periph_id_o), .periph_gnt_i(periph_gnt_i), .periph_r_data_i(periph_r_data_i),
        .periph_r_valid_i(periph_r_valid_i), .periph_r_id_i(periph_r_id_i),
        .mismatch_cnt_o(mismatch_cnt_o), .stat_wr_o(stat_wr_o), .stat_rd_o(stat_rd_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gd;      // REQ cycles before the grant
        int          rd;      // WAIT_R cycles before the matching response
        int          wrong;   // wrong-ID responses injected at the start of WAIT_R (<= rd)
        int          hold;    // cycles rsp_ready_i is held low
        logic        stray;   // r_valid pulses during REQ that must be ignored
        logic [31:0] rin;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[5];

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0]  exp_id = 2'd0;
    logic [15:0] mm_exp = 16'd0;
    logic [31:0] wr_exp = 32'd0;
    logic [31:0] rd_exp = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_stats();
        logic [31:0] ew, er;
`ifdef HWPE_PERIPH_INITIATOR_STATS_EN
        ew = wr_exp;
        er = rd_exp;
`else
        ew = 32'h0;
        er = 32'h0;
`endif
        chk("stat_wr", stat_wr_o, ew);
        chk("stat_rd", stat_rd_o, er);
    endtask

    task automatic do_txn(input vec_t v, input logic [31:0] er);
        logic wen;
        wen = ~v.we;
        chk("cmd_ready_idle", cmd_ready_o, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_addr_i  = v.addr;
        cmd_wdata_i = v.wdata;
        cmd_be_i    = v.be;
        step();
        cmd_valid_i = 1'b0;
        cmd_addr_i  = $urandom;
        cmd_wdata_i = $urandom;
        cmd_we_i    = ~v.we;
        for (int k = 0; k <= v.gd; k++) begin
            chk("req_high", periph_req_o, 32'd1);
            chk("req_add", periph_add_o, v.addr);
            chk("req_wen", periph_wen_o, wen);
            chk("req_be", periph_be_o, v.be);
            chk("req_data", periph_data_o, v.wdata);
            chk("req_id", periph_id_o, exp_id);
            chk("cmd_ready_req", cmd_ready_o, 32'd0);
            chk("rsp_valid_req", rsp_valid_o, 32'd0);
            periph_gnt_i = (k == v.gd);
            if (v.stray) begin
                periph_r_valid_i = 1'b1;
                periph_r_id_i    = exp_id ^ 2'd1;
                periph_r_data_i  = $urandom;
            end
            step();
            periph_gnt_i     = 1'b0;
            periph_r_valid_i = 1'b0;
        end
        for (int j = 0; j <= v.rd; j++) begin
            chk("req_low_wait", periph_req_o, 32'd0);
            chk("rsp_valid_wait", rsp_valid_o, 32'd0);
            if (j == v.rd) begin
                periph_r_valid_i = 1'b1;
                periph_r_id_i    = exp_id;
                periph_r_data_i  = v.rin;
            end else if (j < v.wrong) begin
                periph_r_valid_i = 1'b1;
                periph_r_id_i    = exp_id ^ 2'd1;
                periph_r_data_i  = $urandom;
                mm_exp++;
            end
            step();
            periph_r_valid_i = 1'b0;
        end
        for (int h = 0; h <= v.hold; h++) begin
            chk("rsp_valid", rsp_valid_o, 32'd1);
            chk("rsp_rdata", rsp_rdata_o, er);
            chk("rsp_err", rsp_err_o, 32'd0);
            chk("cmd_ready_resp", cmd_ready_o, 32'd0);
            rsp_ready_i = (h == v.hold);
            step();
            rsp_ready_i = 1'b0;
        end
        if (v.we) wr_exp++;
        else      rd_exp++;
        exp_id++;
        chk("rsp_valid_after", rsp_valid_o, 32'd0);
        chk("mismatch_cnt", mismatch_cnt_o, mm_exp);
        chk_stats();
    endtask

    initial begin
        vec_t v;
        rst_i = 1'b1;
        cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0; cmd_be_i = 0;
        rsp_ready_i = 0; periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_data_i = 0; periph_r_id_i = 0;

        //           we    addr          wdata         be    gd rd wr hold stray rin           exp_rdata
        tbl[0] = '{1'b1, 32'h00100004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 1'b0, 32'hAAAA5555, 32'h0};
        tbl[1] = '{1'b0, 32'h0010000C, 32'h0,        4'hF, 5, 0, 0, 0, 1'b0, 32'h12345678, 32'h12345678};
        tbl[2] = '{1'b0, 32'h00100020, 32'h0,        4'h3, 0, 2, 2, 0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[3] = '{1'b1, 32'h00100024, 32'h01020304, 4'h5, 1, 1, 0, 3, 1'b1, 32'h0BADF00D, 32'h0};
        tbl[4] = '{1'b0, 32'h00100028, 32'h0,        4'hC, 2, 1, 1, 1, 1'b1, 32'h89ABCDEF, 32'h89ABCDEF};

        repeat (2) step();
        chk("rst_cmd_ready", cmd_ready_o, 32'd0);
        chk("rst_req", periph_req_o, 32'd0);
        chk("rst_rsp_valid", rsp_valid_o, 32'd0);
        chk("rst_wen", periph_wen_o, 32'd0);
        chk("rst_id", periph_id_o, 32'd0);
        chk("rst_mismatch", mismatch_cnt_o, 32'd0);
        chk_stats();
        rst_i = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready_o, 32'd1);

        // Ids run 0,1,2,3,0 across the table.
        for (int i = 0; i < 5; i++) do_txn(tbl[i], tbl[i].exp_rdata);

        for (int i = 0; i < 24; i++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.be    = 4'($urandom);
            v.gd    = $urandom_range(0, 2);
            v.rd    = $urandom_range(0, 2);
            v.wrong = $urandom_range(0, v.rd);
            v.hold  = $urandom_range(0, 2);
            v.stray = 1'($urandom_range(0, 1));
            v.rin   = $urandom;
            v.exp_rdata = v.we ? 32'h0 : v.rin;
            do_txn(v, v.exp_rdata);
        end

        // Timeout: never granted; late grant/response in the abort cycle must lose.
        chk("to_cmd_ready", cmd_ready_o, 32'd1);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h00000040; cmd_be_i = 4'hF;
        step();
        cmd_valid_i = 1'b0;
        for (int k = 1; k < 8; k++) begin
            chk("to_req_high", periph_req_o, 32'd1);
            step();
        end
        chk("to_req_drop", periph_req_o, 32'd0);
        chk("to_rsp_not_yet", rsp_valid_o, 32'd0);
        periph_gnt_i = 1'b1; periph_r_valid_i = 1'b1; periph_r_id_i = exp_id; periph_r_data_i = 32'h55AA55AA;
        step();
        periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0;
        chk("to_rsp_valid", rsp_valid_o, 32'd1);
        chk("to_rsp_err", rsp_err_o, 32'd1);
        chk("to_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("to_req_low", periph_req_o, 32'd0);
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        periph_r_valid_i = 1'b1; periph_r_id_i = exp_id; periph_r_data_i = 32'h1;
        exp_id++;
        mm_exp++;
        step();
        periph_r_valid_i = 1'b0;
        chk("to_late_mismatch", mismatch_cnt_o, mm_exp);
        chk("to_next_id", periph_id_o, exp_id);
        chk_stats();

        // Reset while waiting for the response.
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h00000080; cmd_wdata_i = 32'h77; cmd_be_i = 4'hF;
        step();
        cmd_valid_i = 1'b0;
        periph_gnt_i = 1'b1;
        step();
        periph_gnt_i = 1'b0;
        chk("rstw_req_low", periph_req_o, 32'd0);
        rst_i = 1'b1;
        #1;
        chk("rstw_cmd_ready", cmd_ready_o, 32'd0);
        chk("rstw_add", periph_add_o, 32'd0);
        chk("rstw_data", periph_data_o, 32'd0);
        chk("rstw_id", periph_id_o, 32'd0);
        chk("rstw_rsp_valid", rsp_valid_o, 32'd0);
        chk("rstw_mismatch", mismatch_cnt_o, 32'd0);
        step();
        rst_i = 1'b0;
        #1;
        exp_id = 2'd0; mm_exp = 16'd0; wr_exp = 32'd0; rd_exp = 32'd0;
        chk("rstw_cmd_ready_after", cmd_ready_o, 32'd1);
        chk("rstw_rsp_after", rsp_valid_o, 32'd0);
        chk_stats();
        do_txn(tbl[1], tbl[1].exp_rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
